data_mem: RTL and testbench
===========================

Name:
data_mem

Overview:
- Word-organised data memory for the MEM stage of the RV32IC five-stage pipeline.
- Performs byte, half-word and word stores with byte enables, and synchronous reads.
- Registers the MEM-stage pipeline state into the WB-stage state, substituting sign/zero-extended load data for load instructions.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- ADDR_W, 10, log2(DEPTH); word-index width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_we  in  1  store enable.
- i_addr  in  32  byte address; little-endian.
- i_wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- i_mem_state  in  43  MEM state, packed as follows.
  - [42] valid
  - [41] reg_we
  - [40:36] rd
  - [35:33] funct3
  - [32] is_load
  - [31:0] alu_result
- o_rdata  out  32  raw memory word read at the previous cycle's address.
- o_wback_state  out  39  WB state, packed as follows.
  - [38] valid
  - [37] reg_we
  - [36:32] rd
  - [31:0] wb_data

Behaviour:
- Word index = i_addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH bytes.
- Store (i_we=1, independent of valid), on the rising edge.
  - funct3=000 (SB): byte enable = 1 << i_addr[1:0]; lane data = i_wdata[7:0] replicated.
  - funct3=001 (SH): byte enables = 0011 if i_addr[1]=0, else 1100; i_addr[0] ignored (no misalignment trap).
  - All other funct3 values: full word, i_addr[1:0] ignored.
  - Bytes not enabled keep their value.
- Read:
  - Synchronous, 1-cycle latency; o_rdata is registered and updates every cycle.
  - Read-before-write: a store and a read to the same word in the same cycle returns the old word. The next cycle returns the new word.
- Load extraction uses the registered o_rdata together with registered copies of funct3 and i_addr[1:0]. The result drives wb_data combinationally in the WB cycle.
  - LB (000): byte at addr[1:0], sign-extended.
  - LBU (100): same byte, zero-extended.
  - LH (001): half-word at addr[1], sign-extended.
  - LHU (101): same half-word, zero-extended.
  - LW (010) and other codes: full word.
- WB state:
  - valid, reg_we and rd are registered from i_mem_state every edge.
  - wb_data = extracted load data if the registered is_load=1; otherwise the registered alu_result.
- Reset (asynchronous, active-high):
  - o_rdata = 0.
  - All registered fields = 0, so o_wback_state = 0 (valid=0, reg_we=0, wb_data=0).
  - Memory array contents are not reset.
  - A store coinciding with reset asserted is dropped.
  - Release takes effect on the next rising edge.
- No stall or flush inputs: the pipeline register advances every cycle.

Optional Feature:
- Macro: DMEM_INIT_FILE_EN.
- Defined:
  - Adds parameter INIT_FILE (string, default "dmem.hex").
  - Memory is preloaded at elaboration with $readmemh (one 32-bit hex word per line).
- Undefined:
  - No preload.
  - Memory starts X in simulation; the bench must write before reading.

Test Plan:
- SW 0xDEADBEEF at 0x10 (i_we=1), then read 0x10 with LW, valid=1, is_load=1, rd=5 → after one cycle, o_rdata=0xDEADBEEF and o_wback_state = {1,1,5,0xDEADBEEF}.
- SB 0x80 at 0x11 over word 0x00000000, then LB 0x11 → wb_data=0xFFFFFF80. LBU 0x11 → 0x00000080. o_rdata=0x00008000.
- SH 0x8001 at 0x22, then LH 0x22 → 0xFFFF8001. LHU → 0x00008001. LH 0x20 → old lower half, unchanged.
- Non-load (is_load=0, alu_result=0x12345678, rd=3) → next cycle wb_data=0x12345678, rd=3; o_rdata shows the word at i_addr.
- Same-cycle SW 0x11111111 and read at 0x30 (previously 0x22222222) → o_rdata=0x22222222, then 0x11111111 on the following cycle. Address 0x30 + 4*DEPTH aliases to the same word.
- Assert i_rst mid-stream, between clock edges → o_wback_state and o_rdata go to 0 immediately. A store attempted during reset leaves the memory word unchanged.

Source files
------------

// File: rtl/data_mem.sv
// MEM-stage data memory: byte-enabled stores, synchronous read-before-write reads, and the MEM->WB
// pipeline register with load extraction.
module data_mem #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
`ifdef DMEM_INIT_FILE_EN
    ,
    parameter string INIT_FILE = "dmem.hex"
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [42:0] i_mem_state,
    output logic [31:0] o_rdata,
    output logic [38:0] o_wback_state
);

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic [2:0]        st_funct3;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic              unused_addr_bits;

    assign idx              = i_addr[ADDR_W+1:2];
    assign st_funct3        = i_mem_state[35:33];
    // Upper address bits only alias onto the same word.
    assign unused_addr_bits = ^i_addr[31:ADDR_W+2];

    always_comb begin
        be    = 4'b1111;
        wlane = i_wdata;
        case (st_funct3)
            3'b000: begin
                be    = 4'b0001 << i_addr[1:0];
                wlane = {4{i_wdata[7:0]}};
            end
            3'b001: begin
                be    = i_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Array write: a store during reset is dropped; contents are never cleared.
    always_ff @(posedge i_clk) begin
        if (i_we && !i_rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        byte_v = word[8*off +: 8];
        half_v = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{byte_v[7]}}, byte_v};
            3'b100:  res = {24'b0, byte_v};
            3'b001:  res = {{16{half_v[15]}}, half_v};
            3'b101:  res = {16'b0, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

    logic [31:0] rdata_d,  rdata_q;
    logic        valid_d,  valid_q;
    logic        reg_we_d, reg_we_q;
    logic [4:0]  rd_d,     rd_q;
    logic [2:0]  funct3_d, funct3_q;
    logic        is_load_d, is_load_q;
    logic [31:0] alu_d,    alu_q;
    logic [1:0]  off_d,    off_q;

    // Read happens before the non-blocking write above lands: same-cycle read sees the old word.
    always_comb begin
        rdata_d   = mem[idx];
        valid_d   = i_mem_state[42];
        reg_we_d  = i_mem_state[41];
        rd_d      = i_mem_state[40:36];
        funct3_d  = i_mem_state[35:33];
        is_load_d = i_mem_state[32];
        alu_d     = i_mem_state[31:0];
        off_d     = i_addr[1:0];
    end

    // MEM -> WB stage boundary
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            reg_we_q  <= 1'b0;
            rd_q      <= '0;
            funct3_q  <= '0;
            is_load_q <= 1'b0;
            alu_q     <= '0;
            off_q     <= '0;
        end else begin
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            reg_we_q  <= reg_we_d;
            rd_q      <= rd_d;
            funct3_q  <= funct3_d;
            is_load_q <= is_load_d;
            alu_q     <= alu_d;
            off_q     <= off_d;
        end
    end

    logic [31:0] wb_data;

    assign wb_data       = is_load_q ? extract_load(rdata_q, funct3_q, off_q) : alu_q;
    assign o_rdata       = rdata_q;
    assign o_wback_state = {valid_q, reg_we_q, rd_q, wb_data};

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: stores of each width, loads with extension, read-before-write,
// address aliasing and asynchronous reset behaviour.
module tb_data_mem;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [42:0] i_mem_state;
    logic [31:0] o_rdata;
    logic [38:0] o_wback_state;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem #(.DEPTH(1024), .ADDR_W(10)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_we         (i_we),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_mem_state  (i_mem_state),
        .o_rdata      (o_rdata),
        .o_wback_state(o_wback_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [42:0] ms(input logic v, input logic we, input logic [4:0] rd,
                                       input logic [2:0] f3, input logic ld, input logic [31:0] alu);
        return {v, we, rd, f3, ld, alu};
    endfunction

    function automatic logic [38:0] wb(input logic v, input logic we, input logic [4:0] rd,
                                       input logic [31:0] d);
        return {v, we, rd, d};
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        i_we        = 1'b1;
        i_addr      = addr;
        i_wdata     = data;
        i_mem_state = ms(1'b1, 1'b0, 5'd0, f3, 1'b0, addr);
        step();
        i_we        = 1'b0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        i_we        = 1'b0;
        i_addr      = addr;
        i_wdata     = 32'h0;
        i_mem_state = ms(1'b1, 1'b1, rd, f3, 1'b1, addr);
        step();
    endtask

    initial begin
        i_rst       = 1'b1;
        i_we        = 1'b0;
        i_addr      = 32'h0;
        i_wdata     = 32'h0;
        i_mem_state = ms(1'b1, 1'b1, 5'd9, 3'b010, 1'b0, 32'hFFFF_FFFF);
        step();
        check_eq("reset_rdata", 64'(o_rdata), 64'h0);
        check_eq("reset_wb", 64'(o_wback_state), 64'h0);
        i_rst = 1'b0;

        // Word store then LW
        store(3'b010, 32'h10, 32'hDEAD_BEEF);
        load(3'b010, 32'h10, 5'd5);
        check_eq("lw_rdata", 64'(o_rdata), 64'hDEAD_BEEF);
        check_eq("lw_wb", 64'(o_wback_state), 64'(wb(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF)));

        // Byte stores into a zeroed word, then LB/LBU
        store(3'b010, 32'h10, 32'h0);
        store(3'b000, 32'h11, 32'hABCD_EF80);
        load(3'b000, 32'h11, 5'd6);
        check_eq("sb_rdata", 64'(o_rdata), 64'h0000_8000);
        check_eq("lb_neg", 64'(o_wback_state), 64'(wb(1'b1, 1'b1, 5'd6, 32'hFFFF_FF80)));
        load(3'b100, 32'h11, 5'd6);
        check_eq("lbu", 64'(o_wback_state[31:0]), 64'h0000_0080);
        store(3'b000, 32'h13, 32'h0000_007F);
        load(3'b000, 32'h13, 5'd7);
        check_eq("sb_b3_rdata", 64'(o_rdata), 64'h7F00_8000);
        check_eq("lb_pos", 64'(o_wback_state[31:0]), 64'h0000_007F);

        // Half-word stores, addr[0] ignored on SH
        store(3'b010, 32'h20, 32'hCAFE_1234);
        store(3'b001, 32'h22, 32'h5555_8001);
        load(3'b001, 32'h22, 5'd8);
        check_eq("sh_rdata", 64'(o_rdata), 64'h8001_1234);
        check_eq("lh_neg", 64'(o_wback_state[31:0]), 64'hFFFF_8001);
        load(3'b101, 32'h22, 5'd8);
        check_eq("lhu", 64'(o_wback_state[31:0]), 64'h0000_8001);
        load(3'b001, 32'h20, 5'd8);
        check_eq("lh_low", 64'(o_wback_state[31:0]), 64'h0000_1234);
        store(3'b001, 32'h23, 32'h0000_7FFE);
        load(3'b001, 32'h21, 5'd8);
        check_eq("lh_odd_low", 64'(o_wback_state[31:0]), 64'h0000_1234);
        load(3'b101, 32'h23, 5'd8);
        check_eq("lhu_odd_high", 64'(o_wback_state[31:0]), 64'h0000_7FFE);

        // Non-load passes alu_result; o_rdata still shows the addressed word
        i_addr      = 32'h20;
        i_mem_state = ms(1'b1, 1'b1, 5'd3, 3'b000, 1'b0, 32'h1234_5678);
        step();
        check_eq("alu_wb", 64'(o_wback_state), 64'(wb(1'b1, 1'b1, 5'd3, 32'h1234_5678)));
        check_eq("alu_rdata", 64'(o_rdata), 64'h7FFE_1234);
        i_mem_state = ms(1'b0, 1'b0, 5'd4, 3'b010, 1'b0, 32'h0000_00AA);
        step();
        check_eq("bubble_wb", 64'(o_wback_state), 64'(wb(1'b0, 1'b0, 5'd4, 32'h0000_00AA)));

        // Unusual funct3 codes: full-word store ignoring addr[1:0], full-word load
        store(3'b111, 32'h43, 32'hA5A5_5A5A);
        load(3'b011, 32'h40, 5'd10);
        check_eq("odd_f3_word", 64'(o_wback_state[31:0]), 64'hA5A5_5A5A);

        // Read-before-write and aliasing
        store(3'b010, 32'h30, 32'h2222_2222);
        i_we        = 1'b1;
        i_addr      = 32'h30;
        i_wdata     = 32'h1111_1111;
        i_mem_state = ms(1'b1, 1'b1, 5'd7, 3'b010, 1'b1, 32'h30);
        step();
        i_we = 1'b0;
        check_eq("rbw_old", 64'(o_rdata), 64'h2222_2222);
        check_eq("rbw_old_wb", 64'(o_wback_state[31:0]), 64'h2222_2222);
        load(3'b010, 32'h30 + 32'd4096, 5'd7);
        check_eq("rbw_new_alias", 64'(o_rdata), 64'h1111_1111);
        store(3'b010, 32'h0001_0030, 32'h3333_3333);
        load(3'b010, 32'h30, 5'd7);
        check_eq("alias_store", 64'(o_rdata), 64'h3333_3333);

        // Asynchronous reset between edges; a store during reset is dropped
        load(3'b010, 32'h30, 5'd12);
        #2;
        i_rst = 1'b1;
        #1;
        check_eq("async_rst_rdata", 64'(o_rdata), 64'h0);
        check_eq("async_rst_wb", 64'(o_wback_state), 64'h0);
        i_we        = 1'b1;
        i_addr      = 32'h30;
        i_wdata     = 32'hBADB_AD00;
        i_mem_state = ms(1'b1, 1'b0, 5'd0, 3'b010, 1'b0, 32'h30);
        step();
        step();
        check_eq("in_rst_wb", 64'(o_wback_state), 64'h0);
        i_we  = 1'b0;
        #2;
        i_rst = 1'b0;
        load(3'b010, 32'h30, 5'd12);
        check_eq("rst_store_dropped", 64'(o_rdata), 64'h3333_3333);
        check_eq("post_rst_wb", 64'(o_wback_state), 64'(wb(1'b1, 1'b1, 5'd12, 32'h3333_3333)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
